// File: rtl/psum_accum_pkg.sv
// ============================================================================
// Module : psum_accum_pkg
// Brief  : Shared constants, FSM encoding and helpers for psum_accum.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package psum_accum_pkg;

    localparam int col     = 8;
    localparam int psum_bw = 16;
    localparam int IN_W    = 6;
    localparam int K       = 3;
    localparam int OUT_W   = IN_W - K + 1;
    localparam int NIJ     = IN_W * IN_W;
    localparam int ACC_W   = psum_bw + 4;
    localparam int PADDR_W = 11;
    localparam int OADDR_W = 4;
    localparam int KI_W    = $clog2(K);
    localparam int OR_W    = $clog2(OUT_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // In range when all bits above the psum sign bit match it.
    function automatic logic [psum_bw-1:0] sat_psum(input logic [ACC_W-1:0] a);
        if ((&a[ACC_W-1:psum_bw-1]) || (~|a[ACC_W-1:psum_bw-1]))
            return a[psum_bw-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(psum_bw-1){1'b0}}};
        else
            return {1'b0, {(psum_bw-1){1'b1}}};
    endfunction

    function automatic logic [PADDR_W-1:0] paddr_of(input logic [OR_W-1:0] orow,
                                                    input logic [OR_W-1:0] ocol,
                                                    input logic [KI_W-1:0] ki,
                                                    input logic [KI_W-1:0] kj);
        int a;
        a = (int'(ki) * K + int'(kj)) * NIJ
          + (int'(orow) + int'(ki)) * IN_W
          + int'(ocol) + int'(kj);
        return PADDR_W'(a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/psum_accum_lane.sv
// ============================================================================
// Module : psum_lane
// Brief  : One column lane: load/add accumulator, optional ReLU (PSUM_RELU_EN),
//          saturation to psum_bw. Output is registered on every data beat.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_lane
    import psum_accum_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_beat,
    input  logic               i_first,
    input  logic [psum_bw-1:0] i_data,
    output logic [psum_bw-1:0] o_out
);

    logic [ACC_W-1:0]   r_acc;
    logic [psum_bw-1:0] r_out;
    logic [ACC_W-1:0]   w_data_ext;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_relu;

    assign w_data_ext = {{(ACC_W-psum_bw){i_data[psum_bw-1]}}, i_data};
    assign w_acc_next = i_first ? w_data_ext : (r_acc + w_data_ext);

`ifdef PSUM_RELU_EN
    assign w_relu = w_acc_next[ACC_W-1] ? '0 : w_acc_next;
`else
    assign w_relu = w_acc_next;
`endif

    // Post-processing the next sum keeps the output word a pure flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_beat) begin
            r_acc <= w_acc_next;
            r_out <= sat_psum(w_relu);
        end
    end

    assign o_out = r_out;

endmodule

`default_nettype wire

// File: rtl/psum_accum.sv
// ============================================================================
// Module : psum_accum
// Brief  : Sums K*K partial sums per output pixel from psum memory and writes
//          post-processed words to output memory. Option: PSUM_RELU_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_accum
    import psum_accum_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     pmem_cen,
    output logic                     pmem_ren,
    output logic [PADDR_W-1:0]       pmem_addr,
    input  logic [col*psum_bw-1:0]   pmem_rdata,
    output logic                     omem_cen,
    output logic                     omem_wen,
    output logic [OADDR_W-1:0]       omem_addr,
    output logic [col*psum_bw-1:0]   omem_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam logic [KI_W-1:0] c_KMAX = KI_W'(K - 1);
    localparam logic [OR_W-1:0] c_OMAX = OR_W'(OUT_W - 1);

    state_t          r_state, w_ns;
    logic [KI_W-1:0] r_ki, r_kj, w_ki_n, w_kj_n;
    logic [OR_W-1:0] r_orow, r_ocol, w_orow_n, w_ocol_n;
    logic            r_beat, r_first;

    always_comb begin
        w_ns     = r_state;
        w_ki_n   = r_ki;
        w_kj_n   = r_kj;
        w_orow_n = r_orow;
        w_ocol_n = r_ocol;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_ns     = S_READ;
                    w_ki_n   = '0;
                    w_kj_n   = '0;
                    w_orow_n = '0;
                    w_ocol_n = '0;
                end else begin
                    w_ns = S_IDLE;
                end
            end
            S_READ: begin
                if (r_kj == c_KMAX) begin
                    if (r_ki == c_KMAX) begin
                        w_ns = S_DRAIN;
                    end else begin
                        w_kj_n = '0;
                        w_ki_n = r_ki + 1'b1;
                    end
                end else begin
                    w_kj_n = r_kj + 1'b1;
                end
            end
            S_DRAIN: w_ns = S_WRITE;
            S_WRITE: begin
                w_ki_n = '0;
                w_kj_n = '0;
                if (r_ocol == c_OMAX) begin
                    w_ocol_n = '0;
                    if (r_orow == c_OMAX) begin
                        w_orow_n = '0;
                        w_ns     = S_DONE;
                    end else begin
                        w_orow_n = r_orow + 1'b1;
                        w_ns     = S_READ;
                    end
                end else begin
                    w_ocol_n = r_ocol + 1'b1;
                    w_ns     = S_READ;
                end
            end
            default: w_ns = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ki      <= '0;
            r_kj      <= '0;
            r_orow    <= '0;
            r_ocol    <= '0;
            r_beat    <= 1'b0;
            r_first   <= 1'b0;
            pmem_cen  <= 1'b1;
            pmem_ren  <= 1'b1;
            pmem_addr <= '0;
            omem_cen  <= 1'b1;
            omem_wen  <= 1'b1;
            omem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_ns;
            r_ki      <= w_ki_n;
            r_kj      <= w_kj_n;
            r_orow    <= w_orow_n;
            r_ocol    <= w_ocol_n;
            r_beat    <= (r_state == S_READ);
            r_first   <= (r_state == S_READ) && (r_ki == '0) && (r_kj == '0);
            pmem_cen  <= (w_ns != S_READ);
            pmem_ren  <= (w_ns != S_READ);
            pmem_addr <= paddr_of(w_orow_n, w_ocol_n, w_ki_n, w_kj_n);
            omem_cen  <= (w_ns != S_WRITE);
            omem_wen  <= (w_ns != S_WRITE);
            omem_addr <= OADDR_W'(int'(w_orow_n) * OUT_W + int'(w_ocol_n));
            busy      <= (w_ns == S_READ) || (w_ns == S_DRAIN) || (w_ns == S_WRITE);
            done      <= (w_ns == S_DONE);
        end
    end

    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_lane
            psum_lane u_lane (
                .clk     (clk),
                .reset   (reset),
                .i_beat  (r_beat),
                .i_first (r_first),
                .i_data  (pmem_rdata[gi*psum_bw +: psum_bw]),
                .o_out   (omem_wdata[gi*psum_bw +: psum_bw])
            );
        end
    endgenerate

endmodule

`default_nettype wire
